// File: rtl/pipe_hazard_ctrl_gen.sv
// Pipeline stall/flush arbiter: freezes, exception redirects, mispredicts and data hazards
// become per-stage write-enable, bubble-insert and side-effect-disable vectors.
module pipe_hazard_ctrl_gen #(
  parameter int NSTAGE     = 7,
  parameter int BR_STAGE   = 3,
  parameter int EXC_STAGE  = 4,
  parameter int DH_BASE    = 3,
  parameter int NDH        = 3,
  parameter int WDOG_LIMIT = 1024,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              dstall,
  input  logic              istall,
  input  logic              mdu_busy,
  input  logic              exc_flush,
  input  logic              bp_fail,
  input  logic              bp_fail_all,
  input  logic              brlikely_nt,
  input  logic [NDH-1:0]    dh_stall,
  input  logic              perf_clr,
  output logic [NSTAGE-1:0] stage_wr,
  output logic [NSTAGE-1:0] stage_flush,
  output logic [NSTAGE-1:0] stage_diswr,
  output logic              ireq_valid,
  output logic              dreq_valid,
  output logic              icache_stall,
  output logic              dcache_stall,
  output logic              wdog_hit,
  output logic [CNT_W-1:0]  cnt_freeze,
  output logic [CNT_W-1:0]  cnt_dh,
  output logic [CNT_W-1:0]  cnt_flush
);

  localparam int FW = $clog2(WDOG_LIMIT + 1);

  typedef enum logic [2:0] {
    ACT_NORM, ACT_BPF, ACT_DH, ACT_BPA, ACT_EXC, ACT_FRZ
  } act_e;

  act_e             act;
  logic             freeze, exc, dh_any;
  int               dh_idx, dh_b;
  logic             exc_pend_q, exc_pend_d;
  logic [FW-1:0]    frz_cnt_q, frz_cnt_d;
  logic             wdog_q, wdog_d;
  logic [CNT_W-1:0] cnt_freeze_q, cnt_freeze_d;
  logic [CNT_W-1:0] cnt_dh_q, cnt_dh_d;
  logic [CNT_W-1:0] cnt_flush_q, cnt_flush_d;

  always_comb begin
    freeze = dstall | istall | mdu_busy;
    exc    = exc_flush | exc_pend_q;
    dh_any = |dh_stall;
    dh_idx = 0;
    for (int i = 0; i < NDH; i++) begin
      if (dh_stall[i]) dh_idx = i;
    end
    dh_b = DH_BASE + dh_idx;

    if (freeze)           act = ACT_FRZ;
    else if (exc)         act = ACT_EXC;
    else if (bp_fail_all) act = ACT_BPA;
    else if (dh_any)      act = ACT_DH;
    else if (bp_fail)     act = ACT_BPF;
    else                  act = ACT_NORM;

    stage_wr     = '1;
    stage_flush  = '0;
    stage_diswr  = '0;
    icache_stall = 1'b0;
    dcache_stall = 1'b0;
    unique case (act)
      ACT_FRZ: begin
        stage_wr     = '0;
        icache_stall = 1'b1;
        dcache_stall = 1'b1;
        for (int s = 0; s < NSTAGE; s++) stage_diswr[s] = (s >= BR_STAGE);
      end
      ACT_EXC: begin
        for (int s = 0; s < NSTAGE; s++) begin
          stage_wr[s]    = (s == 0) || (s > EXC_STAGE);
          stage_flush[s] = (s >= 1) && (s <= EXC_STAGE);
          stage_diswr[s] = (s >= BR_STAGE) && (s <= EXC_STAGE);
        end
      end
      ACT_BPA, ACT_BPF: begin
        for (int s = 0; s < NSTAGE; s++) begin
          stage_wr[s]    = (s == 0) || (s >= BR_STAGE);
          stage_flush[s] = (s >= 1) && (s <= BR_STAGE);
        end
        // a plain mispredict keeps the branch itself unless it is a not-taken likely branch
        if (act == ACT_BPF) stage_flush[BR_STAGE] = brlikely_nt;
      end
      ACT_DH: begin
        icache_stall = 1'b1;
        for (int s = 0; s < NSTAGE; s++) begin
          stage_wr[s]    = (s >= dh_b);
          stage_flush[s] = (s == dh_b);
          stage_diswr[s] = (s == dh_b - 1);
        end
      end
      default: stage_flush[BR_STAGE] = brlikely_nt;
    endcase

    ireq_valid = ~(exc | dh_any | bp_fail | bp_fail_all);
    dreq_valid = ~exc;

    if (!resetn) begin
      stage_wr     = '0;
      stage_flush  = '1;
      stage_diswr  = '1;
      ireq_valid   = 1'b0;
      dreq_valid   = 1'b0;
      icache_stall = 1'b0;
      dcache_stall = 1'b0;
    end
  end

  always_comb begin
    exc_pend_d = exc_pend_q;
    if (exc && !freeze)          exc_pend_d = 1'b0;
    else if (exc_flush && freeze) exc_pend_d = 1'b1;

    frz_cnt_d = '0;
    if (freeze) frz_cnt_d = (frz_cnt_q != '1) ? frz_cnt_q + FW'(1) : frz_cnt_q;
    wdog_d = wdog_q | (freeze && (frz_cnt_q == FW'(WDOG_LIMIT - 1)));

    cnt_freeze_d = cnt_freeze_q;
    cnt_dh_d     = cnt_dh_q;
    cnt_flush_d  = cnt_flush_q;
    if (perf_clr) begin
      cnt_freeze_d = '0;
      cnt_dh_d     = '0;
      cnt_flush_d  = '0;
    end else begin
      if (act == ACT_FRZ && cnt_freeze_q != '1) cnt_freeze_d = cnt_freeze_q + CNT_W'(1);
      if (act == ACT_DH && cnt_dh_q != '1)      cnt_dh_d     = cnt_dh_q + CNT_W'(1);
      if ((act == ACT_EXC || act == ACT_BPA || act == ACT_BPF) && cnt_flush_q != '1)
        cnt_flush_d = cnt_flush_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      exc_pend_q   <= 1'b0;
      frz_cnt_q    <= '0;
      wdog_q       <= 1'b0;
      cnt_freeze_q <= '0;
      cnt_dh_q     <= '0;
      cnt_flush_q  <= '0;
    end else begin
      exc_pend_q   <= exc_pend_d;
      frz_cnt_q    <= frz_cnt_d;
      wdog_q       <= wdog_d;
      cnt_freeze_q <= cnt_freeze_d;
      cnt_dh_q     <= cnt_dh_d;
      cnt_flush_q  <= cnt_flush_d;
    end
  end

  assign wdog_hit   = wdog_q;
  assign cnt_freeze = cnt_freeze_q;
  assign cnt_dh     = cnt_dh_q;
  assign cnt_flush  = cnt_flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl_gen.sv
// Directed-vector bench for pipe_hazard_ctrl_gen (WDOG_LIMIT=16, CNT_W=4, other defaults).
module tb_pipe_hazard_ctrl_gen;

  logic       clk = 1'b0;
  logic       resetn, dstall, istall, mdu_busy, exc_flush, bp_fail, bp_fail_all, brlikely_nt, perf_clr;
  logic [2:0] dh_stall;
  logic [6:0] stage_wr, stage_flush, stage_diswr;
  logic       ireq_valid, dreq_valid, icache_stall, dcache_stall, wdog_hit;
  logic [3:0] cnt_freeze, cnt_dh, cnt_flush;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_gen #(.WDOG_LIMIT(16), .CNT_W(4)) dut (
    .clk(clk), .resetn(resetn), .dstall(dstall), .istall(istall), .mdu_busy(mdu_busy),
    .exc_flush(exc_flush), .bp_fail(bp_fail), .bp_fail_all(bp_fail_all),
    .brlikely_nt(brlikely_nt), .dh_stall(dh_stall), .perf_clr(perf_clr),
    .stage_wr(stage_wr), .stage_flush(stage_flush), .stage_diswr(stage_diswr),
    .ireq_valid(ireq_valid), .dreq_valid(dreq_valid), .icache_stall(icache_stall),
    .dcache_stall(dcache_stall), .wdog_hit(wdog_hit), .cnt_freeze(cnt_freeze),
    .cnt_dh(cnt_dh), .cnt_flush(cnt_flush)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [6:0] wr, input logic [6:0] fl,
                         input logic [6:0] dw);
    chk({tag, ".wr"}, 32'(stage_wr), 32'(wr));
    chk({tag, ".flush"}, 32'(stage_flush), 32'(fl));
    chk({tag, ".diswr"}, 32'(stage_diswr), 32'(dw));
  endtask

  task automatic chk_side(input string tag, input logic ir, input logic dr, input logic ic,
                          input logic dc);
    chk({tag, ".side"}, {28'd0, ireq_valid, dreq_valid, icache_stall, dcache_stall},
        {28'd0, ir, dr, ic, dc});
  endtask

  task automatic chk_cnt(input string tag, input logic [3:0] fz, input logic [3:0] dh,
                         input logic [3:0] fl);
    chk({tag, ".cnt"}, {20'd0, cnt_freeze, cnt_dh, cnt_flush}, {20'd0, fz, dh, fl});
  endtask

  // args: resetn dstall istall mdu exc_flush bp_fail bp_fail_all brlikely_nt dh perf_clr
  task automatic apply(input logic r, input logic ds, input logic is, input logic md,
                       input logic ef, input logic bf, input logic ba, input logic nt,
                       input logic [2:0] dh, input logic pc);
    resetn = r; dstall = ds; istall = is; mdu_busy = md; exc_flush = ef;
    bp_fail = bf; bp_fail_all = ba; brlikely_nt = nt; dh_stall = dh; perf_clr = pc;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset with freeze and exception requests present: reset outputs must win
    apply(0, 1, 0, 0, 1, 0, 0, 0, 3'b000, 0);
    chk_vec("rst", 7'b0000000, 7'b1111111, 7'b1111111);
    chk_side("rst", 0, 0, 0, 0);
    tick; tick;
    chk_cnt("rst", 0, 0, 0);
    chk("rst.wdog", 32'(wdog_hit), 0);

    apply(1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    chk_vec("norm", 7'b1111111, 7'b0000000, 7'b0000000);
    chk_side("norm", 1, 1, 0, 0);
    tick;
    apply(1, 0, 0, 0, 0, 0, 0, 1, 3'b000, 0);
    chk_vec("norm_nt", 7'b1111111, 7'b0001000, 7'b0000000);
    tick;
    apply(1, 0, 0, 0, 0, 0, 0, 0, 3'b010, 0);
    chk_vec("dh1", 7'b1110000, 7'b0010000, 7'b0001000);
    chk_side("dh1", 0, 1, 1, 0);
    tick;
    apply(1, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0);
    chk_vec("dh_hi", 7'b1100000, 7'b0100000, 7'b0010000);
    tick;
    chk_cnt("dh", 0, 2, 0);
    apply(1, 0, 0, 0, 0, 1, 0, 1, 3'b000, 0);
    chk_vec("bpf_nt", 7'b1111001, 7'b0001110, 7'b0000000);
    chk_side("bpf_nt", 0, 1, 0, 0);
    tick;
    apply(1, 0, 0, 0, 0, 1, 0, 0, 3'b000, 0);
    chk_vec("bpf", 7'b1111001, 7'b0000110, 7'b0000000);
    tick;
    apply(1, 0, 0, 0, 0, 1, 0, 1, 3'b001, 0);
    chk_vec("bpf_dh", 7'b1111000, 7'b0001000, 7'b0000100);
    tick;
    chk_cnt("bpf_dh", 0, 3, 2);
    apply(1, 0, 0, 0, 0, 0, 1, 0, 3'b000, 0);
    chk_vec("bpa", 7'b1111001, 7'b0001110, 7'b0000000);
    tick;
    apply(1, 0, 0, 0, 0, 0, 1, 0, 3'b100, 0);
    chk_vec("bpa_dh", 7'b1111001, 7'b0001110, 7'b0000000);
    chk_side("bpa_dh", 0, 1, 0, 0);
    tick;
    chk_cnt("bpa", 0, 3, 4);

    // exception arriving under a dcache freeze is held until the freeze lifts
    apply(1, 1, 0, 0, 1, 0, 0, 0, 3'b000, 0);
    chk_vec("exc_frz0", 7'b0000000, 7'b0000000, 7'b1111000);
    chk_side("exc_frz0", 0, 0, 1, 1);
    tick;
    apply(1, 1, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    chk_vec("exc_frz1", 7'b0000000, 7'b0000000, 7'b1111000);
    chk_side("exc_frz1", 0, 0, 1, 1);
    tick;
    chk_vec("exc_frz2", 7'b0000000, 7'b0000000, 7'b1111000);
    tick;
    apply(1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    chk_vec("exc_rel", 7'b1100001, 7'b0011110, 7'b0011000);
    chk_side("exc_rel", 0, 0, 0, 0);
    tick;
    chk_vec("exc_done", 7'b1111111, 7'b0000000, 7'b0000000);
    chk_side("exc_done", 1, 1, 0, 0);
    chk_cnt("exc", 3, 3, 5);

    // two exception pulses during one freeze merge into a single redirect
    apply(1, 0, 1, 0, 1, 0, 0, 0, 3'b000, 0);
    tick;
    apply(1, 0, 0, 1, 1, 0, 0, 0, 3'b000, 0);
    chk_vec("merge_frz", 7'b0000000, 7'b0000000, 7'b1111000);
    tick;
    apply(1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    chk_vec("merge_rel", 7'b1100001, 7'b0011110, 7'b0011000);
    tick;
    chk("merge_done.dreq", 32'(dreq_valid), 1);
    chk_cnt("merge", 5, 3, 6);

    // direct exception outranks mispredict and data hazards
    apply(1, 0, 0, 0, 1, 0, 1, 1, 3'b111, 0);
    chk_vec("exc_pri", 7'b1100001, 7'b0011110, 7'b0011000);
    chk_side("exc_pri", 0, 0, 0, 0);
    tick;
    apply(1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    chk("exc_pri_done.dreq", 32'(dreq_valid), 1);
    chk_cnt("exc_pri", 5, 3, 7);

    // watchdog: 15 freeze cycles is not enough, the 16th trips it; counter saturates
    apply(1, 0, 1, 0, 0, 0, 0, 0, 3'b000, 0);
    for (int i = 0; i < 15; i++) tick;
    chk("wdog_15", 32'(wdog_hit), 0);
    tick;
    chk("wdog_16", 32'(wdog_hit), 1);
    chk("sat_freeze", 32'(cnt_freeze), 32'hF);
    for (int i = 0; i < 4; i++) tick;
    chk("sat_hold", 32'(cnt_freeze), 32'hF);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    tick; tick;
    chk("wdog_sticky", 32'(wdog_hit), 1);
    chk_vec("post_wdog", 7'b1111111, 7'b0000000, 7'b0000000);

    // clear beats a same-cycle increment
    apply(1, 0, 1, 0, 0, 0, 0, 0, 3'b000, 1);
    tick;
    apply(1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    chk_cnt("clr", 0, 0, 0);
    chk("clr.wdog", 32'(wdog_hit), 1);
    tick;

    // reset mid-freeze with a pending exception drops the redirect
    apply(1, 1, 0, 0, 1, 0, 0, 0, 3'b000, 0);
    tick;
    apply(1, 1, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    tick;
    apply(0, 1, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    chk_vec("rst_mid", 7'b0000000, 7'b1111111, 7'b1111111);
    chk_side("rst_mid", 0, 0, 0, 0);
    tick;
    apply(1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    chk_vec("rst_nored", 7'b1111111, 7'b0000000, 7'b0000000);
    chk_side("rst_nored", 1, 1, 0, 0);
    chk_cnt("rst_mid", 0, 0, 0);
    chk("rst_mid.wdog", 32'(wdog_hit), 0);
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
